// File: rtl/mips32_fetch_unit_if.sv
// rtl/mips32_fetch_unit_if.sv - instruction-memory and IF/ID handshake bundle for the fetch unit
interface mips32_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_npc;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_halted;

    modport master (
        output imem_req, imem_addr, if_valid, if_ir, if_npc, fetch_halted,
        input  imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_ir, if_npc, fetch_halted,
        output imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/mips32_fetch_unit.sv
// rtl/mips32_fetch_unit.sv - decoupled MIPS32 fetch front end with prefetch FIFO, redirect and HLT stop
module mips32_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [5:0]  HLT_OPC  = 6'b111100
) (
    input logic             clk,
    input logic             rst,
    mips32_fetch_unit_if.master bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0]   ir_mem_q  [DEPTH];
    logic [31:0]   npc_mem_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d, count_after;
    logic [31:0]   pc_q, pc_d, addr_q, addr_d;
    logic [31:0]   last_ir_q, last_ir_d, last_npc_q, last_npc_d;
    logic          req_q, req_d, out_q, out_d, drop_q, drop_d, halt_q, halt_d;
    logic          resp, pop, push, hlt_push, issue, head_valid;

    assign head_valid = (count_q != '0);

    always_comb begin
        resp        = out_q && bus.imem_rvalid;
        pop         = head_valid && bus.id_ready && !bus.redirect;
        push        = resp && !drop_q && !bus.redirect;
        hlt_push    = push && (bus.imem_rdata[31:26] == HLT_OPC);
        count_after = count_q + (AW+1)'(push) - (AW+1)'(pop);
        // A response landing this cycle frees the single outstanding slot, so
        // the next request can go out on the same edge (one word every two cycles).
        issue       = (!out_q || resp) && !halt_q && !hlt_push && !bus.redirect
                      && (count_after < DEPTH_C);

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = 1'b0;
        out_d      = out_q;
        drop_d     = drop_q;
        halt_d     = halt_q;
        last_ir_d  = last_ir_q;
        last_npc_d = last_npc_q;

        if (head_valid) begin
            last_ir_d  = ir_mem_q[rd_ptr_q];
            last_npc_d = npc_mem_q[rd_ptr_q];
        end

        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = bus.redirect_pc;
            halt_d   = 1'b0;
            // An in-flight word belongs to the old path; remember to discard it.
            out_d    = out_q && !bus.imem_rvalid;
            drop_d   = out_q && !bus.imem_rvalid;
        end else begin
            req_d   = issue;
            count_d = count_after;
            halt_d  = halt_q || hlt_push;
            if (issue) begin
                addr_d = pc_q;
                pc_d   = pc_q + 32'd1;
            end
            if (issue)
                out_d = 1'b1;
            else if (resp)
                out_d = 1'b0;
            if (resp)
                drop_d = 1'b0;
            if (push)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            req_q      <= 1'b0;
            out_q      <= 1'b0;
            drop_q     <= 1'b0;
            halt_q     <= 1'b0;
            last_ir_q  <= '0;
            last_npc_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            halt_q     <= halt_d;
            last_ir_q  <= last_ir_d;
            last_npc_q <= last_npc_d;
        end
    end

    // Payload storage needs no reset: it is only visible while count_q says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem_q[wr_ptr_q]  <= bus.imem_rdata;
            npc_mem_q[wr_ptr_q] <= addr_q + 32'd1;
        end
    end

    assign bus.imem_req     = req_q;
    assign bus.imem_addr    = addr_q;
    assign bus.if_valid     = head_valid;
    assign bus.if_ir        = head_valid ? ir_mem_q[rd_ptr_q]  : last_ir_q;
    assign bus.if_npc       = head_valid ? npc_mem_q[rd_ptr_q] : last_npc_q;
    assign bus.fetch_halted = halt_q;
endmodule
